// File: rtl/lsu_memory_if.sv
// lsu_memory_if: request/response bus between the core's MEM stage and lsu_memory.
// master = core side (drives requests), slave = memory side (drives ready and responses).
interface lsu_memory_if #(parameter int ADDRW = 10) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [ADDRW-1:0] req_addr;
  logic [31:0]      req_wdata;
  logic             resp_valid;
  logic [31:0]      resp_rdata;
  logic             resp_err;
  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/lsu_memory.sv
// lsu_memory: latency-configurable little-endian data memory with valid/ready requests and error responses.
// Ports: clk, rst_n (async active-low), bus (lsu_memory_if.slave: req_* in, req_ready/resp_* out).
module lsu_memory #(
  parameter int ADDRW   = 10,
  parameter int LATENCY = 2
) (
  input logic         clk,
  input logic         rst_n,
  lsu_memory_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [3:0][7:0]  mem [1<<(ADDRW-2)];
  logic [31:0]      word;
  logic [3:0][7:0]  wlane;
  logic [7:0]       b;
  logic [15:0]      h;
  logic [1:0]       len, off;
  logic [3:0]       be;
  logic             err, wr;
  always_comb begin
    len = f3_q[1:0];
    off = addr_q[1:0];
    word = mem[addr_q[ADDRW-1:2]];
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    err = (len == 2'd3) | (len == 2'd1 & off[0]) | (len == 2'd2 & |off) | (we_q & f3_q[2]);
    wr = state_q == WAIT && cnt_q == 4'd0 && we_q && !err;
    // replicate store data across lanes; be picks which lanes actually land
    be = len == 2'd0 ? 4'b0001 << off : len == 2'd1 ? 4'b0011 << off : 4'b1111;
    wlane = len == 2'd0 ? {4{wdata_q[7:0]}} : len == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    f3_d = f3_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = WAIT;
        cnt_d = 4'(LATENCY - 1);
        we_d = bus.req_we;
        f3_d = bus.req_funct3;
        addr_d = bus.req_addr;
        wdata_d = bus.req_wdata;
      end
      WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        state_d = RESP;
        err_d = err;
        rdata_d = (err | we_q) ? 32'd0 :
                  len == 2'd0 ? {{24{~f3_q[2] & b[7]}}, b} :
                  len == 2'd1 ? {{16{~f3_q[2] & h[15]}}, h} : word;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      we_q <= 1'b0;
      f3_q <= 3'd0;
      addr_q <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  // storage is deliberately not reset; the write enable is qualified by reset state
  always_ff @(posedge clk)
    if (wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr_q[ADDRW-1:2]][i] <= wlane[i];
  assign bus.req_ready = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err = err_q;
endmodule

// File: tb/tb_lsu_memory.sv
// tb_lsu_memory: directed bench for lsu_memory with a byte-array reference model checked every cycle.
module tb_lsu_memory;
  localparam int AW = 10;
  localparam int SIZE = 1 << AW;
  localparam int L = 3;
  logic clk = 0;
  logic rst_n = 0;
  lsu_memory_if #(.ADDRW(AW)) bus ();
  lsu_memory #(.ADDRW(AW), .LATENCY(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  bit run = 0;
  logic [7:0] mem_m [SIZE];
  bit busy = 0;
  int cyc = 0, e0 = 0;
  logic [31:0] exp_rd = 0, pend_rd;
  logic exp_er = 0, pend_er;
  logic m_we;
  logic [2:0] m_f3;
  int m_a;
  logic [31:0] m_wd;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic void predict(input logic we, input logic [2:0] f3, input int a,
                                  output logic [31:0] rd, output logic er);
    int n;
    n = 1 << f3[1:0];
    er = (f3[1:0] == 2'd3) || (a % n != 0) || (we && f3[2]);
    rd = 0;
    if (!er && !we) begin
      for (int i = 0; i < n; i++) rd |= 32'(mem_m[(a + i) % SIZE]) << (8 * i);
      if (!f3[2] && n < 4 && rd[8*n-1]) rd |= 32'hFFFFFFFF << (8 * n);
    end
  endfunction
  // reference model: a request taken in idle answers L edges later, busy one more edge
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      busy = 0;
      exp_rd = 0;
      exp_er = 0;
    end else begin
      cyc++;
      if (!busy) begin
        if (bus.req_valid) begin
          busy = 1;
          e0 = cyc;
          m_we = bus.req_we;
          m_f3 = bus.req_funct3;
          m_a = int'(bus.req_addr);
          m_wd = bus.req_wdata;
          predict(m_we, m_f3, m_a, pend_rd, pend_er);
        end
      end else if (cyc == e0 + L) begin
        exp_rd = pend_rd;
        exp_er = pend_er;
        if (m_we && !pend_er)
          for (int i = 0; i < (1 << m_f3[1:0]); i++) mem_m[(m_a + i) % SIZE] = 8'(m_wd >> (8 * i));
      end else if (cyc == e0 + L + 1) busy = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (run) begin
      chk("ready", 32'(bus.req_ready), 32'(!busy));
      chk("valid", 32'(bus.resp_valid), 32'(busy && cyc == e0 + L));
      chk("rdata", bus.resp_rdata, exp_rd);
      chk("err", 32'(bus.resp_err), 32'(exp_er));
    end
  end
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
    lat = 0;
    while (lat < 40 && !bus.resp_valid) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.resp_valid) begin
      tests++;
      fails++;
      $display("FAIL timeout: no resp_valid for addr %h", a);
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.req_valid = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    bus.req_valid = 0;
    bus.req_we = 0;
    bus.req_funct3 = 0;
    bus.req_addr = 0;
    bus.req_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_valid", 32'(bus.resp_valid), 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    #2 rst_n = 1;
    run = 1;
    repeat (5) @(negedge clk);
    do_req(1, 3'b010, 0, 32'hA74D2F93, rd, er, lat);
    chk("sw_lat", lat, 4);
    chk("sw_err", 32'(er), 0);
    do_req(1, 3'b010, 4, 0, rd, er, lat);
    do_req(1, 3'b010, 8, 0, rd, er, lat);
    do_req(0, 3'b010, 0, 0, rd, er, lat);
    chk("lw0", rd, 32'hA74D2F93);
    do_req(1, 3'b000, 5, 32'h00000086, rd, er, lat);
    do_req(0, 3'b010, 4, 0, rd, er, lat);
    chk("lw4_sb", rd, 32'h00008600);
    do_req(0, 3'b010, 0, 0, rd, er, lat);
    chk("lw0_iso", rd, 32'hA74D2F93);
    do_req(0, 3'b000, 0, 0, rd, er, lat);
    chk("lb0", rd, 32'hFFFFFF93);
    do_req(0, 3'b100, 0, 0, rd, er, lat);
    chk("lbu0", rd, 32'h00000093);
    do_req(0, 3'b001, 2, 0, rd, er, lat);
    chk("lh2", rd, 32'hFFFFA74D);
    do_req(0, 3'b101, 2, 0, rd, er, lat);
    chk("lhu2", rd, 32'h0000A74D);
    do_req(0, 3'b001, 0, 0, rd, er, lat);
    chk("lh0", rd, 32'h00002F93);
    do_req(0, 3'b010, 1, 0, rd, er, lat);
    chk("lw1_err", 32'(er), 1);
    chk("lw1_rdata", rd, 0);
    chk("err_lat", lat, 4);
    do_req(1, 3'b001, 3, 32'hFFFF, rd, er, lat);
    chk("sh3_err", 32'(er), 1);
    do_req(0, 3'b011, 0, 0, rd, er, lat);
    chk("f3_011_err", 32'(er), 1);
    do_req(1, 3'b100, 0, 32'hFFFFFFFF, rd, er, lat);
    chk("st_unsigned_err", 32'(er), 1);
    do_req(0, 3'b010, 0, 0, rd, er, lat);
    chk("lw0_after_err", rd, 32'hA74D2F93);
    chk("lw0_after_err_e", 32'(er), 0);
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_we = 1;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 8;
    bus.req_wdata = 32'h12345678;
    @(negedge clk);
    bus.req_valid = 0;
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.req_ready), 1);
    chk("midrst_valid", 32'(bus.resp_valid), 0);
    do_req(0, 3'b010, 8, 0, rd, er, lat);
    chk("lw8_dropped", rd, 32'h00000000);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
